// File: rtl/dht11_responder.sv
// -----------------------------------------------------------------------------
// dht11_responder
//   Responder end of the DHT11 single-wire protocol. It watches the
//   open-drain data line for a host start pulse. It then sends the 80 us
//   low / 80 us high acknowledge and a 40-bit frame: hum_int, hum_dec,
//   temp_int, temp_dec and the checksum, MSB first. Each bit is a 50 us low
//   followed by a 26 us (bit 0) or 70 us (bit 1) high. A final 50 us low
//   closes the frame.
//
//   Optional feature macro: DHT_FAULT_INJECT_EN
//     When defined, the err_inj input is added. It is sampled when the frame
//     is latched, and err_inj=1 flips bit 0 of the transmitted checksum.
//
// Parameters
//   CLK_HZ        hwclk frequency; an integer multiple of 1 MHz, >= 2 MHz
//   START_MIN_US  minimum host low time (us) accepted as a start request
//                 (must fit the 15-bit us counter)
//   RESP_WAIT_US  delay from host release to the responder pulling low
//
// Ports
//   hwclk       in   system clock (only clock)
//   rst         in   asynchronous, active-high reset
//   dq_in       in   data line as seen at the pad, asynchronous to hwclk
//   dq_oe       out  1 = pull the line low, 0 = release it to the pull-up
//   hum_int     in   humidity integer byte
//   hum_dec     in   humidity decimal byte
//   temp_int    in   temperature integer byte
//   temp_dec    in   temperature decimal byte
//   err_inj     in   (DHT_FAULT_INJECT_EN only) corrupt the checksum
//   busy        out  high from start acceptance until the end of END_LOW
//   frame_done  out  one-cycle pulse as END_LOW completes
//   dbg_state   out  current FSM state, for observation only
//
// Handshake: there is no valid/ready interface. The data bytes are sampled
// on the single cycle the start request is accepted. After that they may
// change freely without affecting the frame in flight.
// -----------------------------------------------------------------------------
module dht11_responder #(
   parameter int CLK_HZ       = 12_000_000,
   parameter int START_MIN_US = 18000,
   parameter int RESP_WAIT_US = 30
) (
   input  logic       hwclk,
   input  logic       rst,
   input  logic       dq_in,
   output logic       dq_oe,
   input  logic [7:0] hum_int,
   input  logic [7:0] hum_dec,
   input  logic [7:0] temp_int,
   input  logic [7:0] temp_dec,
`ifdef DHT_FAULT_INJECT_EN
   input  logic       err_inj,
`endif
   output logic       busy,
   output logic       frame_done,
   output logic [2:0] dbg_state
);

   localparam int DIV = CLK_HZ / 1_000_000;
   localparam int PW  = $clog2(DIV);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_HOST_LOW = 3'd1,
      S_WAIT_REL = 3'd2,
      S_ACK_LOW  = 3'd3,
      S_ACK_HIGH = 3'd4,
      S_BIT_LOW  = 3'd5,
      S_BIT_HIGH = 3'd6,
      S_END_LOW  = 3'd7
   } state_t;

   state_t      state, state_next;
   logic [1:0]  sync_q;
   logic        dq_s;
   logic [PW-1:0] pre_cnt;
   logic        tick;
   logic [14:0] us_cnt;
   logic [39:0] shreg;
   logic [5:0]  bit_idx;
   logic        latch_frame;
   logic        shift_bit;
   logic        end_frame;
   logic [14:0] bit_high_last;
   logic [7:0]  csum;
   logic [7:0]  csum_tx;

   // 2-FF synchronizer. It resets to 1 because the idle line is pulled up.
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], dq_in};
   end
   assign dq_s = sync_q[1];

   // Free-running 1 us prescaler. A state entry does not realign it, which
   // gives the +0/-1 tick quantization of every interval.
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst)                          pre_cnt <= '0;
      else if (pre_cnt == PW'(DIV - 1)) pre_cnt <= '0;
      else                              pre_cnt <= pre_cnt + 1'b1;
   end
   assign tick = (pre_cnt == PW'(DIV - 1));

   // Microseconds spent in the current state. It saturates at all-ones.
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst)                          us_cnt <= '0;
      else if (state_next != state)     us_cnt <= '0;
      else if (tick && us_cnt != '1)    us_cnt <= us_cnt + 1'b1;
   end

   assign csum = hum_int + hum_dec + temp_int + temp_dec;
`ifdef DHT_FAULT_INJECT_EN
   assign csum_tx = csum ^ {7'd0, err_inj};
`else
   assign csum_tx = csum;
`endif

   // The final tick of the bit-high interval depends on the bit being sent.
   assign bit_high_last = shreg[39] ? 15'd69 : 15'd25;

   // State register
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next state. An interval of N us ends on the tick where us_cnt == N-1.
   always_comb begin
      state_next = state;
      end_frame  = 1'b0;
      case (state)
         S_IDLE:     if (!dq_s) state_next = S_HOST_LOW;
         S_HOST_LOW: begin
            if (dq_s) begin
               if (us_cnt >= 15'(START_MIN_US)) state_next = S_WAIT_REL;
               else                             state_next = S_IDLE;
            end
         end
         S_WAIT_REL: if (tick && us_cnt == 15'(RESP_WAIT_US - 1)) state_next = S_ACK_LOW;
         S_ACK_LOW:  if (tick && us_cnt == 15'd79) state_next = S_ACK_HIGH;
         S_ACK_HIGH: if (tick && us_cnt == 15'd79) state_next = S_BIT_LOW;
         S_BIT_LOW:  if (tick && us_cnt == 15'd49) state_next = S_BIT_HIGH;
         S_BIT_HIGH: begin
            if (tick && us_cnt == bit_high_last) begin
               if (bit_idx == 6'd39) state_next = S_END_LOW;
               else                  state_next = S_BIT_LOW;
            end
         end
         S_END_LOW: begin
            if (tick && us_cnt == 15'd49) begin
               state_next = S_IDLE;
               end_frame  = 1'b1;
            end
         end
         default:    state_next = S_IDLE;
      endcase
   end

   assign latch_frame = (state == S_HOST_LOW) && (state_next == S_WAIT_REL);
   assign shift_bit   = (state == S_BIT_HIGH) && (state_next != S_BIT_HIGH);

   // Frame shift register and bit index
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         shreg   <= '0;
         bit_idx <= '0;
      end else if (latch_frame) begin
         shreg   <= {hum_int, hum_dec, temp_int, temp_dec, csum_tx};
         bit_idx <= '0;
      end else if (shift_bit) begin
         shreg   <= {shreg[38:0], 1'b0};
         bit_idx <= bit_idx + 1'b1;
      end
   end

   // frame_done is registered on the END_LOW exit edge, so it coincides with
   // the release of dq_oe.
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) frame_done <= 1'b0;
      else     frame_done <= end_frame;
   end

   // dq_oe is decoded from the state register. The asynchronous reset of
   // that register releases the line immediately.
   always_comb begin
      dq_oe = 1'b0;
      busy  = 1'b0;
      case (state)
         S_ACK_LOW, S_BIT_LOW, S_END_LOW: dq_oe = 1'b1;
         default:                         dq_oe = 1'b0;
      endcase
      case (state)
         S_WAIT_REL, S_ACK_LOW, S_ACK_HIGH,
         S_BIT_LOW, S_BIT_HIGH, S_END_LOW: busy = 1'b1;
         default:                          busy = 1'b0;
      endcase
   end

   assign dbg_state = state;

endmodule
